// File: rtl/gpio_sw_pkg.sv
// Shared definitions for the GPIO switch reader: register offsets inside
// the 4-word read window, read FSM state encoding and the default base address.
package gpio_sw_pkg;

    localparam logic [1:0]  SW_OFF_LO  = 2'd0;
    localparam logic [1:0]  SW_OFF_HI  = 2'd1;
    localparam logic [1:0]  CHG_OFF_LO = 2'd2;
    localparam logic [1:0]  CHG_OFF_HI = 2'd3;

    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'hFF00;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_e;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch channel: 2-flop synchroniser, 2-deep sample history taken on
// each prescaler tick, debounced level and a sticky change flag.
// A debounce commit and a clear on the same edge leave the flag set.
module sw_debounce_bit (
    input  logic clock,
    input  logic reset,
    input  logic sw_raw_i,
    input  logic tick_i,
    input  logic clr_i,
    output logic stable_o,
    output logic chg_o
);

    logic       s1_q;
    logic       s2_q;
    logic [1:0] hist_q;
    logic [1:0] hist_d;
    logic       stable_q;
    logic       stable_d;
    logic       chg_q;
    logic       chg_d;
    logic       commit;

    // Next-state: shift history on tick, commit after three agreeing samples.
    always_comb begin
        commit   = 1'b0;
        hist_d   = hist_q;
        stable_d = stable_q;
        chg_d    = chg_q;
        if (tick_i) begin
            hist_d = {hist_q[0], s2_q};
            commit = (hist_q[1] == s2_q) && (hist_q[0] == s2_q) && (s2_q != stable_q);
        end
        if (commit) begin
            stable_d = s2_q;
        end
        if (commit) begin
            chg_d = 1'b1;
        end else if (clr_i) begin
            chg_d = 1'b0;
        end
    end

    // Synchroniser and debounce state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            hist_q   <= 2'b00;
            stable_q <= 1'b0;
            chg_q    <= 1'b0;
        end else begin
            s1_q     <= sw_raw_i;
            s2_q     <= s1_q;
            hist_q   <= hist_d;
            stable_q <= stable_d;
            chg_q    <= chg_d;
        end
    end

    assign stable_o = stable_q;
    assign chg_o    = chg_q;

endmodule

// File: rtl/gpio_switch_reader.sv
// GPIO switch reader: debounces 32 board switches and exposes the stable
// levels and clear-on-read change flags on a single-cycle read bus.
// Optional interrupt output enabled by defining GPIO_SW_READER_IRQ_EN.
module gpio_switch_reader
    import gpio_sw_pkg::*;
#(
    parameter int          NUM_SW          = 32,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          CNT_W           = 20,
    parameter logic [15:0] BASE_ADDR       = DEFAULT_BASE_ADDR
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_SW-1:0] sw_raw,
    input  logic              rd_req,
    input  logic [15:0]       rd_addr,
    output logic [15:0]       rd_data,
    output logic              rd_valid,
    output logic [NUM_SW-1:0] sw_stable
`ifdef GPIO_SW_READER_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              tick;
    logic [NUM_SW-1:0] stable_vec;
    logic [NUM_SW-1:0] chg_vec;
    logic [NUM_SW-1:0] clr_vec;
    logic [15:0]       addr_off;
    logic [1:0]        sel;
    logic              in_win;
    logic              clr_lo;
    logic              clr_hi;
    logic [15:0]       word;
    rd_state_e         state_q;
    rd_state_e         state_d;
    logic [15:0]       rd_data_q;
    logic [15:0]       rd_data_d;

    // Prescaler: one tick every DEBOUNCE_CYCLES clocks.
    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Prescaler register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Low half of the flags is cleared by offset 2, high half by offset 3.
    assign clr_vec = {{(NUM_SW/2){clr_hi}}, {(NUM_SW/2){clr_lo}}};

    generate
        for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_sw
            sw_debounce_bit u_bit (
                .clock    (clock),
                .reset    (reset),
                .sw_raw_i (sw_raw[gi]),
                .tick_i   (tick),
                .clr_i    (clr_vec[gi]),
                .stable_o (stable_vec[gi]),
                .chg_o    (chg_vec[gi])
            );
        end
    endgenerate

    // Address decode and register-window read mux.
    always_comb begin
        addr_off = rd_addr - BASE_ADDR;
        sel      = addr_off[1:0];
        in_win   = rd_req && (addr_off[15:2] == 14'd0);
        clr_lo   = in_win && (sel == CHG_OFF_LO);
        clr_hi   = in_win && (sel == CHG_OFF_HI);
        case (sel)
            SW_OFF_LO:  word = stable_vec[15:0];
            SW_OFF_HI:  word = stable_vec[31:16];
            CHG_OFF_LO: word = chg_vec[15:0];
            default:    word = chg_vec[31:16];
        endcase
    end

    // Read FSM next-state: every in-window request yields one response cycle.
    always_comb begin
        state_d   = state_q;
        rd_data_d = 16'h0000;
        case (state_q)
            RD_IDLE: begin
                if (in_win) begin
                    state_d   = RD_RESP;
                    rd_data_d = word;
                end
            end
            RD_RESP: begin
                if (in_win) begin
                    state_d   = RD_RESP;
                    rd_data_d = word;
                end else begin
                    state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // Read FSM state and response data registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RD_IDLE;
            rd_data_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_valid  = (state_q == RD_RESP);
    assign rd_data   = rd_data_q;
    assign sw_stable = stable_vec;

`ifdef GPIO_SW_READER_IRQ_EN
    logic irq_q;

    // Interrupt follows any pending change flag, one cycle later.
    always_ff @(posedge clock) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |chg_vec;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_gpio_switch_reader.sv
// Directed testbench for gpio_switch_reader with DEBOUNCE_CYCLES=4.
module tb_gpio_switch_reader;

    localparam int DC = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] sw_raw = 32'h0;
    logic        rd_req = 1'b0;
    logic [15:0] rd_addr = 16'h0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [31:0] sw_stable;
`ifdef GPIO_SW_READER_IRQ_EN
    logic        irq;
`endif

    int cyc = 0;
    int r0 = 0;
    int pass_cnt = 0;
    int total_cnt = 0;

    gpio_switch_reader #(
        .NUM_SW          (32),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (3),
        .BASE_ADDR       (16'hFF00)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .sw_raw    (sw_raw),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .sw_stable (sw_stable)
`ifdef GPIO_SW_READER_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // First tick edge numbered >= m; ticks land on edges r0+4, r0+8, ...
    function automatic int next_tick(input int m);
        int n;
        n = m;
        while ((n <= r0) || (((n - r0) % DC) != 0)) n++;
        return n;
    endfunction

    // Edge on which a raw change made just after edge k becomes stable.
    function automatic int predict_commit(input int k);
        return next_tick(k + 3) + 2 * DC;
    endfunction

    task automatic do_read(input logic [15:0] a, output logic [15:0] d, output logic v);
        @(negedge clock);
        rd_req  = 1'b1;
        rd_addr = a;
        @(negedge clock);
        d = rd_data;
        v = rd_valid;
        rd_req = 1'b0;
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        sw_raw = 32'h0;
        repeat (3) @(negedge clock);
        total_cnt++;
        if (sw_stable !== 32'h0) $display("FAIL reset_sw_stable: got %h expected %h", sw_stable, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b expected 0", rd_valid);
        else pass_cnt++;
        total_cnt++;
        if (rd_data !== 16'h0) $display("FAIL reset_rd_data: got %h expected 0000", rd_data);
        else pass_cnt++;
`ifdef GPIO_SW_READER_IRQ_EN
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq);
        else pass_cnt++;
`endif
        reset = 1'b0;
        r0 = cyc;
        $display("reset released after edge %0d", r0);
        repeat (40) @(negedge clock);
    endtask

    task automatic test_idle_reads;
        logic [15:0] d;
        logic        v;
        for (int off = 0; off < 4; off++) begin
            do_read(16'hFF00 + 16'(off), d, v);
            $display("read off %0d: valid=%b data=%h", off, v, d);
            total_cnt++;
            if (v !== 1'b1 || d !== 16'h0000)
                $display("FAIL idle_read_%0d: got valid=%b data=%h expected valid=1 data=0000", off, v, d);
            else pass_cnt++;
            @(negedge clock);
            total_cnt++;
            if (rd_valid !== 1'b0 || rd_data !== 16'h0000)
                $display("FAIL idle_read_drop_%0d: got valid=%b data=%h expected valid=0 data=0000", off, rd_valid, rd_data);
            else pass_cnt++;
        end
    endtask

    task automatic test_debounce;
        int          k;
        int          pred;
        int          n;
        logic [15:0] d;
        logic        v;
        @(negedge clock);
        sw_raw = 32'h0001_8000;
        k    = cyc;
        pred = predict_commit(k);
        n    = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (sw_stable === 32'h0001_8000) begin
                n = cyc;
                break;
            end
        end
        $display("debounce commit: edge %0d predicted %0d", n, pred);
        total_cnt++;
        if (n != pred) $display("FAIL debounce_commit_edge: got %0d expected %0d", n, pred);
        else pass_cnt++;
        total_cnt++;
        if (n < 0 || (n - k) > 14) $display("FAIL debounce_latency: got %0d expected <=14", n - k);
        else pass_cnt++;
        do_read(16'hFF02, d, v);
        $display("read chg lo: valid=%b data=%h", v, d);
        total_cnt++;
        if (v !== 1'b1 || d !== 16'h8000) $display("FAIL chg_lo_first: got %h expected 8000", d);
        else pass_cnt++;
        do_read(16'hFF03, d, v);
        $display("read chg hi: valid=%b data=%h", v, d);
        total_cnt++;
        if (v !== 1'b1 || d !== 16'h0001) $display("FAIL chg_hi_first: got %h expected 0001", d);
        else pass_cnt++;
        do_read(16'hFF02, d, v);
        $display("reread chg lo: valid=%b data=%h", v, d);
        total_cnt++;
        if (v !== 1'b1 || d !== 16'h0000) $display("FAIL chg_lo_cleared: got %h expected 0000", d);
        else pass_cnt++;
    endtask

    task automatic test_glitch;
        logic [15:0] d;
        logic        v;
        @(negedge clock);
        sw_raw[5] = 1'b1;
        repeat (3) @(negedge clock);
        sw_raw[5] = 1'b0;
        repeat (20) @(negedge clock);
        $display("after glitch: sw_stable=%h", sw_stable);
        total_cnt++;
        if (sw_stable !== 32'h0001_8000) $display("FAIL glitch_stable: got %h expected 00018000", sw_stable);
        else pass_cnt++;
        do_read(16'hFF02, d, v);
        $display("read chg lo after glitch: valid=%b data=%h", v, d);
        total_cnt++;
        if (v !== 1'b1 || d !== 16'h0000) $display("FAIL glitch_chg: got %h expected 0000", d);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_data [4];
        exp_data = '{16'h8000, 16'h0001, 16'h0000, 16'h0000};
        @(negedge clock);
        rd_req  = 1'b1;
        rd_addr = 16'hFF00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            $display("b2b read %0d: valid=%b data=%h", i, rd_valid, rd_data);
            total_cnt++;
            if (rd_valid !== 1'b1 || rd_data !== exp_data[i])
                $display("FAIL b2b_%0d: got valid=%b data=%h expected valid=1 data=%h", i, rd_valid, rd_data, exp_data[i]);
            else pass_cnt++;
            rd_addr = (i < 3) ? 16'hFF01 + 16'(i) : 16'hFF04;
        end
        @(negedge clock);
        $display("read FF04: valid=%b data=%h", rd_valid, rd_data);
        total_cnt++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h0000)
            $display("FAIL out_of_window_hi: got valid=%b data=%h expected valid=0 data=0000", rd_valid, rd_data);
        else pass_cnt++;
        rd_addr = 16'hFEFF;
        @(negedge clock);
        $display("read FEFF: valid=%b data=%h", rd_valid, rd_data);
        total_cnt++;
        if (rd_valid !== 1'b0) $display("FAIL out_of_window_lo: got valid=%b expected 0", rd_valid);
        else pass_cnt++;
        rd_req = 1'b0;
    endtask

    task automatic test_collision;
        int          k;
        int          nc;
        logic [15:0] d;
        logic        v;
        @(negedge clock);
        sw_raw[0] = 1'b1;
        k  = cyc;
        nc = predict_commit(k);
        for (int i = 0; i < 40 && cyc < nc - 1; i++) @(negedge clock);
        rd_req  = 1'b1;
        rd_addr = 16'hFF02;
        @(negedge clock);
        rd_req = 1'b0;
        $display("collision read: edge %0d valid=%b data=%h stable0=%b", cyc, rd_valid, rd_data, sw_stable[0]);
        total_cnt++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h0000)
            $display("FAIL collision_read: got valid=%b data=%h expected valid=1 data=0000", rd_valid, rd_data);
        else pass_cnt++;
        total_cnt++;
        if (sw_stable[0] !== 1'b1) $display("FAIL collision_commit: got %b expected 1", sw_stable[0]);
        else pass_cnt++;
        do_read(16'hFF02, d, v);
        $display("read after collision: valid=%b data=%h", v, d);
        total_cnt++;
        if (v !== 1'b1 || d !== 16'h0001) $display("FAIL collision_set_wins: got %h expected 0001", d);
        else pass_cnt++;
        do_read(16'hFF02, d, v);
        $display("second read after collision: valid=%b data=%h", v, d);
        total_cnt++;
        if (v !== 1'b1 || d !== 16'h0000) $display("FAIL collision_cleared: got %h expected 0000", d);
        else pass_cnt++;
    endtask

    task automatic test_irq;
        int          k;
        int          nc;
        logic [15:0] d;
        logic        v;
        @(negedge clock);
        sw_raw[20] = 1'b1;
        k  = cyc;
        nc = predict_commit(k);
        for (int i = 0; i < 40 && cyc < nc; i++) @(negedge clock);
        $display("bit20 commit edge %0d: stable20=%b", cyc, sw_stable[20]);
        total_cnt++;
        if (sw_stable[20] !== 1'b1) $display("FAIL bit20_commit: got %b expected 1", sw_stable[20]);
        else pass_cnt++;
`ifdef GPIO_SW_READER_IRQ_EN
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL irq_not_early: got %b expected 0", irq);
        else pass_cnt++;
        @(negedge clock);
        $display("irq after chg set: %b", irq);
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL irq_set: got %b expected 1", irq);
        else pass_cnt++;
`endif
        do_read(16'hFF03, d, v);
        $display("read chg hi: valid=%b data=%h", v, d);
        total_cnt++;
        if (v !== 1'b1 || d !== 16'h0010) $display("FAIL chg_hi_bit20: got %h expected 0010", d);
        else pass_cnt++;
`ifdef GPIO_SW_READER_IRQ_EN
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL irq_hold: got %b expected 1", irq);
        else pass_cnt++;
        @(negedge clock);
        $display("irq after clear: %b", irq);
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL irq_clear: got %b expected 0", irq);
        else pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid_read;
        @(negedge clock);
        rd_req  = 1'b1;
        rd_addr = 16'hFF00;
        @(negedge clock);
        total_cnt++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h8001)
            $display("FAIL pre_reset_read: got valid=%b data=%h expected valid=1 data=8001", rd_valid, rd_data);
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clock);
        $display("reset mid-read: valid=%b data=%h stable=%h", rd_valid, rd_data, sw_stable);
        total_cnt++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h0000 || sw_stable !== 32'h0)
            $display("FAIL reset_mid_read: got valid=%b data=%h stable=%h expected 0/0000/00000000", rd_valid, rd_data, sw_stable);
        else pass_cnt++;
        rd_req = 1'b0;
        reset  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_reads();
        test_debounce();
        test_glitch();
        test_back_to_back();
        test_collision();
        test_irq();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
